int_issue_queue: RTL and testbench

- Integer reservation-station queue between the dispatcher and the integer execution unit.
- Accepts int_fifo_data entries from dispatch and holds them until both source operands are valid.
- Snoops the CDB to capture pending operands, and presents the oldest ready entry as int_issue_data to the issue arbiter.
- Clears all contents on a retire-bus flush (branch misprediction).

---
 rtl/int_issue_queue.sv | 125 ++++++++++++
 tb/tb_int_issue_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/int_issue_queue.sv
// Integer reservation-station queue: age-ordered compacting storage with CDB snoop,
// oldest-ready issue selection and flush on branch misprediction.
module int_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dispatch_en,
  input  logic [100:0]     dispatch_data,
  output logic             queue_full,
  output logic             queue_empty,
  input  logic [40:0]      cdb,
  input  logic             flush,
  input  logic             issue_grant,
  output logic [101:0]     issue_data,
  output logic [CNT_W-1:0] occupancy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW    = 101;

  // Entry layout: {opcode[100:94], func3[93:91], func7[90:84], rd_tag[83:78],
  //   rs1_tag[77:72], rs1_data[71:40], rs1_vld[39], rs2_tag[38:33], rs2_data[32:1], rs2_vld[0]}
  logic [DW-1:0]    ent_q [DEPTH];
  logic [DW-1:0]    ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [5:0]       cdb_tag;
  logic             cdb_valid;
  logic [31:0]      cdb_result;
  logic             unused_cdb;

  logic             rdy_any;
  logic [IDX_W-1:0] sel;
  logic             issue_rdy;
  logic             issue_fire;
  logic             disp_acc;
  logic [CNT_W-1:0] disp_slot;

  assign cdb_tag    = cdb[40:35];
  assign cdb_valid  = cdb[34];
  assign cdb_result = cdb[33:2];
  assign unused_cdb = ^cdb[1:0];

  function automatic logic [DW-1:0] snoop(input logic [DW-1:0] e, input logic cv,
                                          input logic [5:0] ct, input logic [31:0] cr);
    logic [DW-1:0] r;
    r = e;
    if (cv && !e[39] && (e[77:72] == ct)) begin
      r[71:40] = cr;
      r[39]    = 1'b1;
    end
    if (cv && !e[0] && (e[38:33] == ct)) begin
      r[32:1] = cr;
      r[0]    = 1'b1;
    end
    return r;
  endfunction

  // Lowest-index ready entry wins: scanning downward leaves the oldest one selected.
  always_comb begin
    rdy_any = 1'b0;
    sel     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && ent_q[i][39] && ent_q[i][0]) begin
        rdy_any = 1'b1;
        sel     = IDX_W'(i);
      end
    end
  end

  assign issue_rdy  = rdy_any & ~flush;
  assign issue_fire = issue_rdy & issue_grant;
  assign queue_full  = (count_q == CNT_W'(DEPTH));
  assign queue_empty = (count_q == '0);
  assign occupancy   = count_q;
  assign disp_acc    = dispatch_en & ~queue_full & ~flush;
  assign disp_slot   = count_q - {{(CNT_W-1){1'b0}}, issue_fire};
  assign issue_data  = issue_rdy ? {1'b1, ent_q[sel]} : '0;

  // Compaction, snoop on the post-shift slot, then dispatch into the first free slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      int src;
      src = (i < DEPTH - 1) ? i + 1 : i;
      if (issue_fire && (i >= int'(sel))) begin
        ent_d[i] = snoop(ent_q[src], cdb_valid, cdb_tag, cdb_result);
        vld_d[i] = (i < DEPTH - 1) ? vld_q[src] : 1'b0;
      end else begin
        ent_d[i] = snoop(ent_q[i], cdb_valid, cdb_tag, cdb_result);
        vld_d[i] = vld_q[i];
      end
      if (disp_acc && (i == int'(disp_slot))) begin
        ent_d[i] = snoop(dispatch_data, cdb_valid, cdb_tag, cdb_result);
        vld_d[i] = 1'b1;
      end
    end
    if (flush) vld_d = '0;
  end

  always_comb begin
    count_d = count_q;
    if (flush)                       count_d = '0;
    else if (disp_acc && !issue_fire) count_d = count_q + 1'b1;
    else if (!disp_acc && issue_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  // Payload storage is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue with a queue-based reference model checked every cycle.
module tb_int_issue_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             dispatch_en;
  logic [100:0]     dispatch_data;
  logic             queue_full, queue_empty;
  logic [40:0]      cdb;
  logic             flush;
  logic             issue_grant;
  logic [101:0]     issue_data;
  logic [CNT_W-1:0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  int_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .dispatch_en(dispatch_en), .dispatch_data(dispatch_data),
    .queue_full(queue_full), .queue_empty(queue_empty), .cdb(cdb), .flush(flush),
    .issue_grant(issue_grant), .issue_data(issue_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [100:0] mk(input logic [5:0] rd, input logic [5:0] t1,
                                      input logic [31:0] d1, input logic v1,
                                      input logic [5:0] t2, input logic [31:0] d2,
                                      input logic v2);
    return {7'h33, 3'h1, 7'h20, rd, t1, d1, v1, t2, d2, v2};
  endfunction

  function automatic logic [40:0] mkcdb(input logic [5:0] t, input logic [31:0] r);
    return {t, 1'b1, r, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [101:0] act, input logic [101:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain ordered list of entries, oldest first.
  logic [100:0] mq[$];

  function automatic logic [100:0] msnoop(input logic [100:0] e, input logic [40:0] c);
    logic [100:0] r;
    r = e;
    if (c[34]) begin
      if (!r[39] && r[77:72] == c[40:35]) begin r[71:40] = c[33:2]; r[39] = 1'b1; end
      if (!r[0]  && r[38:33] == c[40:35]) begin r[32:1]  = c[33:2]; r[0]  = 1'b1; end
    end
    return r;
  endfunction

  function automatic int first_ready();
    foreach (mq[i]) if (mq[i][39] && mq[i][0]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mq.delete();
    else if (flush) mq.delete();
    else begin
      int k;
      bit accept;
      logic [100:0] nw;
      k      = first_ready();
      accept = dispatch_en && (mq.size() < DEPTH);
      nw     = msnoop(dispatch_data, cdb);
      if (k >= 0 && issue_grant) mq.delete(k);
      foreach (mq[i]) mq[i] = msnoop(mq[i], cdb);
      if (accept) mq.push_back(nw);
    end
  end

  always @(negedge clk) begin
    int k;
    logic [101:0] exp_issue;
    k = first_ready();
    exp_issue = (k >= 0 && !flush) ? {1'b1, mq[k]} : '0;
    chk("issue_data", issue_data, exp_issue);
    chk("occupancy", 102'(occupancy), 102'(mq.size()));
    chk("queue_full", 102'(queue_full), 102'(mq.size() == DEPTH));
    chk("queue_empty", 102'(queue_empty), 102'(mq.size() == 0));
  end

  task automatic drive(input logic en, input logic [100:0] d, input logic [40:0] c,
                       input logic fl, input logic gr);
    dispatch_en = en; dispatch_data = d; cdb = c; flush = fl; issue_grant = gr;
  endtask

  task automatic cyc(input logic en, input logic [100:0] d, input logic [40:0] c,
                     input logic fl, input logic gr);
    drive(en, d, c, fl, gr);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("rst_occ", 102'(occupancy), 102'(0));
    chk("rst_empty", 102'(queue_empty), 102'(1));
    chk("rst_full", 102'(queue_full), 102'(0));
    chk("rst_issue", issue_data, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ready dispatch with grant held
    cyc(1'b1, mk(6'h05, 6'h00, 32'h1, 1'b1, 6'h00, 32'h2, 1'b1), '0, 1'b0, 1'b1);
    chk("t1_rdy", 102'(issue_data[101]), 102'(1));
    chk("t1_rd", 102'(issue_data[83:78]), 102'(6'h05));
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("t1_empty", 102'(queue_empty), 102'(1));
    chk("t1_occ", 102'(occupancy), 102'(0));

    // CDB wakeup of rs1
    cyc(1'b1, mk(6'h06, 6'h0A, 32'h0, 1'b0, 6'h00, 32'h7, 1'b1), '0, 1'b0, 1'b0);
    chk("t2_notrdy", 102'(issue_data[101]), 102'(0));
    cyc(1'b0, '0, mkcdb(6'h0A, 32'hDEADBEEF), 1'b0, 1'b0);
    chk("t2_rdy", 102'(issue_data[101]), 102'(1));
    chk("t2_rs1", 102'(issue_data[71:40]), 102'(32'hDEADBEEF));
    chk("t2_rs1v", 102'(issue_data[39]), 102'(1));
    cyc(1'b0, '0, '0, 1'b0, 1'b1);

    // Same-cycle capture of rs2 during dispatch
    cyc(1'b1, mk(6'h07, 6'h00, 32'h3, 1'b1, 6'h11, 32'h0, 1'b0), mkcdb(6'h11, 32'h1234), 1'b0, 1'b0);
    chk("t3_rdy", 102'(issue_data[101]), 102'(1));
    chk("t3_rs2", 102'(issue_data[32:1]), 102'(32'h1234));
    cyc(1'b0, '0, '0, 1'b0, 1'b1);

    // Oldest ready first, full, dropped dispatch
    cyc(1'b1, mk(6'h20, 6'h01, 32'h0, 1'b0, 6'h00, 32'h9, 1'b1), '0, 1'b0, 1'b0);
    cyc(1'b1, mk(6'h21, 6'h00, 32'h9, 1'b1, 6'h02, 32'h0, 1'b0), '0, 1'b0, 1'b0);
    cyc(1'b1, mk(6'h22, 6'h00, 32'h4, 1'b1, 6'h00, 32'h5, 1'b1), '0, 1'b0, 1'b0);
    cyc(1'b1, mk(6'h23, 6'h00, 32'h6, 1'b1, 6'h00, 32'h7, 1'b1), '0, 1'b0, 1'b0);
    chk("t4_full", 102'(queue_full), 102'(1));
    chk("t4_occ4", 102'(occupancy), 102'(4));
    chk("t4_first", 102'(issue_data[83:78]), 102'(6'h22));
    cyc(1'b1, mk(6'h24, 6'h00, 32'h0, 1'b1, 6'h00, 32'h0, 1'b1), '0, 1'b0, 1'b1);
    chk("t4_occ3", 102'(occupancy), 102'(3));
    chk("t4_second", 102'(issue_data[83:78]), 102'(6'h23));
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("t4_occ2", 102'(occupancy), 102'(2));

    // Simultaneous issue + dispatch at occupancy 2
    cyc(1'b0, '0, mkcdb(6'h02, 32'hAA), 1'b0, 1'b0);
    chk("t5_wake", 102'(issue_data[83:78]), 102'(6'h21));
    cyc(1'b1, mk(6'h26, 6'h03, 32'h0, 1'b0, 6'h00, 32'h1, 1'b1), '0, 1'b0, 1'b1);
    chk("t5_occ", 102'(occupancy), 102'(2));
    chk("t5_none", 102'(issue_data[101]), 102'(0));
    cyc(1'b0, '0, mkcdb(6'h03, 32'hBB), 1'b0, 1'b0);
    chk("t5_new", 102'(issue_data[83:78]), 102'(6'h26));
    cyc(1'b0, '0, mkcdb(6'h01, 32'hCC), 1'b0, 1'b0);
    chk("t5_old", 102'(issue_data[83:78]), 102'(6'h20));
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("t5_after", 102'(issue_data[83:78]), 102'(6'h26));

    // Flush with 3 entries, dispatch and grant in the same cycle
    cyc(1'b1, mk(6'h30, 6'h00, 32'h1, 1'b1, 6'h00, 32'h1, 1'b1), '0, 1'b0, 1'b0);
    cyc(1'b1, mk(6'h31, 6'h00, 32'h1, 1'b1, 6'h00, 32'h1, 1'b1), '0, 1'b0, 1'b0);
    chk("t6_occ3", 102'(occupancy), 102'(3));
    drive(1'b1, mk(6'h32, 6'h00, 32'h1, 1'b1, 6'h00, 32'h1, 1'b1), '0, 1'b1, 1'b1);
    #1;
    chk("t6_flush_rdy", 102'(issue_data[101]), 102'(0));
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("t6_occ0", 102'(occupancy), 102'(0));
    chk("t6_empty", 102'(queue_empty), 102'(1));

    // Asynchronous reset mid-stream
    cyc(1'b1, mk(6'h40, 6'h00, 32'h1, 1'b1, 6'h00, 32'h1, 1'b1), '0, 1'b0, 1'b0);
    cyc(1'b1, mk(6'h41, 6'h00, 32'h1, 1'b1, 6'h00, 32'h1, 1'b1), '0, 1'b0, 1'b0);
    drive(1'b1, mk(6'h42, 6'h00, 32'h1, 1'b1, 6'h00, 32'h1, 1'b1), '0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_occ", 102'(occupancy), 102'(0));
    chk("t7_empty", 102'(queue_empty), 102'(1));
    chk("t7_full", 102'(queue_full), 102'(0));
    chk("t7_issue", issue_data, '0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
